fifo_burst_sched: RTL and testbench

//  Read-side scheduler for the 8-bit/256-deep input FIFO. Decides when to drain it, reads a burst
//  one word at a time and forwards it to the downstream transmitter as a packet on a valid/ready

---
 rtl/fifo_sched_pkg.sv | 21 ++
 rtl/fifo_sched_timer.sv | 30 +++
 rtl/fifo_burst_sched.sv | 144 ++++++++++++++
 tb/tb_fifo_burst_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// rtl/fifo_sched_pkg.sv - shared types, widths and checksum helper for the FIFO burst scheduler
package fifo_sched_pkg;

  localparam int BYTE_W    = 8;
  localparam int PKT_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  // Two's-complement of the running sum so that header + payload + checksum wraps to zero.
  function automatic logic [BYTE_W-1:0] csum_byte(input logic [BYTE_W-1:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_sched_timer.sv
// rtl/fifo_sched_timer.sv - saturating idle timeout counter for the burst scheduler
module fifo_sched_timer #(
  parameter int TIMEOUT = 1000,
  parameter int TIMER_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] ONE   = TIMER_W'(1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + ONE;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/fifo_burst_sched.sv
// rtl/fifo_burst_sched.sv - FIFO read-side burst scheduler emitting length/payload packets
// Optional trailing checksum byte enabled by defining FIFO_SCHED_CSUM_EN.
module fifo_burst_sched
  import fifo_sched_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int THRESH    = 8,
  parameter int TIMEOUT   = 1000,
  parameter int TIMER_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BYTE_W-1:0]    fifo_cnt,
  input  logic [BYTE_W-1:0]    fifo_data,
  output logic                 fifo_rd_en,
  output logic [BYTE_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  localparam logic [BYTE_W-1:0] MAX_B = BYTE_W'(MAX_BURST);
  localparam logic [BYTE_W-1:0] THR   = BYTE_W'(THRESH);

  state_t            state;
  logic [BYTE_W-1:0] remaining;
`ifdef FIFO_SCHED_CSUM_EN
  logic [BYTE_W-1:0] sum;
`endif

  logic              timer_expired;
  logic              timer_clear;
  logic              timer_count;
  logic              start;
  logic [BYTE_W-1:0] start_len;

  assign start_len   = (fifo_cnt > MAX_B) ? MAX_B : fifo_cnt;
  assign start       = (state == ST_IDLE) && enable &&
                       ((fifo_cnt >= THR) || ((fifo_cnt != '0) && timer_expired));
  assign timer_count = (state == ST_IDLE) && (fifo_cnt != '0) && (fifo_cnt < THR);
  assign timer_clear = (state != ST_IDLE) || (fifo_cnt == '0) || start;

  fifo_sched_timer #(
    .TIMEOUT (TIMEOUT),
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (timer_expired)
  );

  // tx_data doubles as the latched length while the header is on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
`ifdef FIFO_SCHED_CSUM_EN
      sum        <= '0;
`endif
      fifo_rd_en <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= start_len;
`ifdef FIFO_SCHED_CSUM_EN
            sum       <= start_len;
`endif
            tx_data   <= start_len;
            tx_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            fifo_rd_en <= 1'b1;
            state      <= ST_RD;
          end
        end
        ST_RD: begin
          fifo_rd_en <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          tx_data   <= fifo_data;
`ifdef FIFO_SCHED_CSUM_EN
          sum       <= sum + fifo_data;
`endif
          remaining <= remaining - 8'd1;
          tx_valid  <= 1'b1;
          state     <= ST_DATA;
        end
        ST_DATA: begin
          if (tx_ready) begin
            if (remaining != '0) begin
              tx_valid   <= 1'b0;
              fifo_rd_en <= 1'b1;
              state      <= ST_RD;
            end else begin
`ifdef FIFO_SCHED_CSUM_EN
              tx_data <= csum_byte(sum);
              state   <= ST_CSUM;
`else
              tx_valid <= 1'b0;
              tx_data  <= '0;
              busy     <= 1'b0;
              pkt_cnt  <= pkt_cnt + 16'd1;
              state    <= ST_IDLE;
`endif
            end
          end
        end
`ifdef FIFO_SCHED_CSUM_EN
        ST_CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            pkt_cnt  <= pkt_cnt + 16'd1;
            state    <= ST_IDLE;
          end
        end
`endif
        default: begin
          fifo_rd_en <= 1'b0;
          tx_valid   <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// tb/tb_fifo_burst_sched.sv - self-checking bench for fifo_burst_sched with a FIFO and packet model
module tb_fifo_burst_sched;

  localparam int MAX_BURST = 16;
  localparam int THRESH    = 8;
  localparam int TIMEOUT   = 1000;
`ifdef FIFO_SCHED_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  fifo_cnt;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  fifo_burst_sched #(
    .MAX_BURST (MAX_BURST),
    .THRESH    (THRESH),
    .TIMEOUT   (TIMEOUT),
    .TIMER_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_cnt   (fifo_cnt),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  typedef struct {
    int n;
    int pat;
    int rmode;
    int stall;
    int exp_pkts;
    int exp_wait;
    int exp_busy;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] fifo_q[$];
  logic [7:0] new_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rd_pulses;
  int         hold_err;
  int         rd_empty_err;
  int         ready_mode;
  int         stall_left;
  int         exp_pkt_cnt;
  bit         stall_prev;
  logic [7:0] prev_data;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic update_cnt();
    fifo_cnt = 8'((fifo_q.size() > 255) ? 255 : fifo_q.size());
  endtask

  // One clock: FIFO read model, handshake bookkeeping and tx_ready policy, all at the falling edge.
  task automatic step();
    @(negedge clk);
    if (fifo_rd_en) begin
      rd_pulses++;
      if (fifo_q.size() == 0) rd_empty_err++;
      else fifo_data = fifo_q.pop_front();
    end
    update_cnt();
    if (stall_prev && (!tx_valid || tx_data != prev_data)) hold_err++;
    tx_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (stall_left > 0 && tx_valid && got_q.size() == 2) begin
      tx_ready = 1'b0;
      stall_left--;
    end
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    stall_prev = tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic push_n(input int n, input int pat);
    logic [7:0] v;
    new_q.delete();
    for (int i = 0; i < n; i++) begin
      if (pat == 0)      v = 8'(i + 1);
      else if (pat == 1) v = 8'(170 + 17 * i);
      else               v = 8'($urandom);
      new_q.push_back(v);
      fifo_q.push_back(v);
    end
    update_cnt();
  endtask

  // Expected byte stream for a block of bytes sitting in an otherwise empty FIFO.
  task automatic expect_burst();
    int pos = 0;
    int len;
    int s;
    while (pos < new_q.size()) begin
      len = new_q.size() - pos;
      if (len > MAX_BURST) len = MAX_BURST;
      exp_q.push_back(8'(len));
      s = len;
      for (int j = 0; j < len; j++) begin
        exp_q.push_back(new_q[pos + j]);
        s += int'(new_q[pos + j]);
      end
      pos += len;
      if (CS == 1) exp_q.push_back(8'((256 - (s % 256)) % 256));
      exp_pkt_cnt++;
    end
  endtask

  task automatic drain(input int budget, output int wait_steps, output int busy_steps);
    int k = 0;
    wait_steps = -1;
    busy_steps = 0;
    do begin
      step();
      k++;
      if (tx_valid && wait_steps < 0) wait_steps = k;
      if (busy) busy_steps++;
    end while (!(fifo_q.size() == 0 && !busy) && k < budget);
    check("drain_done", int'(fifo_q.size() == 0 && !busy), 1);
  endtask

  task automatic compare_stream(input string tag);
    int mism = 0;
    check({tag, "_stream_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_stream_bytes"}, mism, 0);
    check({tag, "_pkt_cnt"}, int'(pkt_cnt), exp_pkt_cnt);
    check({tag, "_hold"}, hold_err, 0);
    check({tag, "_rd_empty"}, rd_empty_err, 0);
  endtask

  task automatic begin_test(input int rmode, input int stall);
    got_q.delete();
    exp_q.delete();
    rd_pulses    = 0;
    hold_err     = 0;
    rd_empty_err = 0;
    ready_mode   = rmode;
    stall_left   = stall ? 5 : 0;
  endtask

  task automatic run_test(input string tag, input vec_t v);
    int w;
    int b;
    int pkts_before;
    begin_test(v.rmode, v.stall);
    pkts_before = exp_pkt_cnt;
    push_n(v.n, v.pat);
    expect_burst();
    drain(4000, w, b);
    compare_stream(tag);
    check({tag, "_pkts"}, int'(pkt_cnt), pkts_before + v.exp_pkts);
    check({tag, "_rd_pulses"}, rd_pulses, v.n);
    check({tag, "_first_valid"}, w, v.exp_wait);
    if (v.exp_busy >= 0) check({tag, "_busy_cycles"}, b, v.exp_busy + CS * v.exp_pkts);
  endtask

  initial begin
    int   w;
    int   b;
    int   idle_err;
    vec_t rv;

    vecs[0] = '{8,   0, 0, 0, 1,  1,           25};
    vecs[1] = '{3,   1, 0, 0, 1,  TIMEOUT + 1, 10};
    vecs[2] = '{40,  2, 0, 0, 3,  1,           123};
    vecs[3] = '{8,   2, 0, 1, 1,  1,           30};
    vecs[4] = '{17,  2, 1, 0, 2,  1,           -1};
    vecs[5] = '{255, 2, 1, 0, 16, 1,           -1};
    vecs[6] = '{1,   2, 0, 0, 1,  TIMEOUT + 1, 4};
    vecs[7] = '{16,  0, 0, 0, 1,  1,           49};

    rst         = 1'b1;
    enable      = 1'b1;
    tx_ready    = 1'b0;
    fifo_cnt    = 8'd0;
    fifo_data   = 8'd0;
    ready_mode  = 0;
    stall_left  = 0;
    stall_prev  = 1'b0;
    prev_data   = 8'd0;
    exp_pkt_cnt = 0;
    step();
    step();
    check("reset_rd_en", int'(fifo_rd_en), 0);
    check("reset_tx_valid", int'(tx_valid), 0);
    check("reset_tx_data", int'(tx_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pkt_cnt", int'(pkt_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_test($sformatf("vec%0d", i), vecs[i]);

    // enable drops while payload byte 4 of 8 is on the wire
    begin_test(0, 0);
    push_n(8, 0);
    expect_burst();
    for (int k = 0; k < 100; k++) begin
      step();
      if (got_q.size() == 5 && tx_valid) break;
    end
    enable = 1'b0;
    drain(200, w, b);
    compare_stream("en_drop");
    push_n(8, 2);
    idle_err = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx_valid || busy || fifo_rd_en) idle_err++;
    end
    check("en_low_idle", idle_err, 0);
    enable = 1'b1;
    expect_burst();
    drain(200, w, b);
    compare_stream("en_resume");
    check("en_resume_wait", w, 1);

    // asynchronous reset while a payload byte is presented
    begin_test(0, 0);
    push_n(8, 2);
    for (int k = 0; k < 100; k++) begin
      step();
      if (got_q.size() == 4 && tx_valid) break;
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rd_en", int'(fifo_rd_en), 0);
    check("midrst_tx_valid", int'(tx_valid), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pkt_cnt", int'(pkt_cnt), 0);
    @(negedge clk);
    rst         = 1'b0;
    stall_prev  = 1'b0;
    exp_pkt_cnt = 0;
    begin_test(0, 0);
    new_q = fifo_q;
    expect_burst();
    drain(4000, w, b);
    compare_stream("post_rst");
    check("post_rst_rd_pulses", rd_pulses, new_q.size());
    check("post_rst_wait", w, (new_q.size() >= THRESH) ? 1 : TIMEOUT + 1);

    // randomized bursts under random backpressure
    for (int r = 0; r < 10; r++) begin
      rv.n        = int'($urandom_range(1, 60));
      rv.pat      = 2;
      rv.rmode    = 1;
      rv.stall    = 0;
      rv.exp_pkts = (rv.n + MAX_BURST - 1) / MAX_BURST;
      rv.exp_wait = (rv.n >= THRESH) ? 1 : TIMEOUT + 1;
      rv.exp_busy = -1;
      run_test($sformatf("rand%0d", r), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
